stat_seq_bench: RTL and testbench



---
 rtl/stat_seq_bench.sv | 143 ++++++++++++++
 tb/tb_stat_seq_bench.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stat_seq_bench.sv
// stat_seq_bench: a pipelined, stallable benchmark core. Input words pass
// through DEPTH registered layers of fixed mixed gates. Each layer also XORs in
// a copy of a state register, and that state register changes with every
// accepted word.
//
// Parameters:
//   WIDTH  data and state width (>= 4)
//   DEPTH  number of registered layers (>= 1), which is also the latency
//   SEED   reset value of the state register, truncated to WIDTH
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready    input handshake; in_data is the offered word
//   out_valid/out_ready  output handshake; out_data is the result word
//   key                  static layer-0 key, present only when STAT_SEQ_KEY_EN
//                        is defined
// Optional feature macro: STAT_SEQ_KEY_EN
module stat_seq_bench #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned SEED  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef STAT_SEQ_KEY_EN
  ,
  input  logic [WIDTH-1:0] key
`endif
);

  localparam logic [WIDTH-1:0] SEED_W = WIDTH'(SEED);

  // Gate-select masks: bit i is set in MASKn when i%4 == n.
  localparam int unsigned NIB = (WIDTH + 3) / 4;
  localparam logic [4*NIB-1:0] M0_FULL = {NIB{4'b0001}};
  localparam logic [4*NIB-1:0] M1_FULL = {NIB{4'b0010}};
  localparam logic [4*NIB-1:0] M2_FULL = {NIB{4'b0100}};
  localparam logic [4*NIB-1:0] M3_FULL = {NIB{4'b1000}};
  localparam logic [WIDTH-1:0] MASK0 = M0_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] MASK1 = M1_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] MASK2 = M2_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] MASK3 = M3_FULL[WIDTH-1:0];

  // Result bit i is v[(i+n) % WIDTH].
  function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] v,
                                            input int unsigned n);
    logic [2*WIDTH-1:0] dbl;
    dbl = {v, v} >> (n % WIDTH);
    return dbl[WIDTH-1:0];
  endfunction

  // One gate layer. Bit i pairs x[i] with x[i+1]; all four gate types are
  // computed as whole vectors, and the masks pick one of them per bit.
  function automatic logic [WIDTH-1:0] gate_layer(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] b;
    b = rotr(x, 1);
    return (((x & b) & MASK0) | ((x | b) & MASK1) |
            ((x ^ b) & MASK2) | (~(x & b) & MASK3)) ^ c;
  endfunction

  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] scap_q [DEPTH];
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] s_d;

  logic [DEPTH-1:0] free;   // stage k loads new contents this cycle
  logic [DEPTH-1:0] vin;    // valid bit offered to stage k
  logic [WIDTH-1:0] lin_x [DEPTH];
  logic [WIDTH-1:0] lin_s [DEPTH];
  logic [WIDTH-1:0] y     [DEPTH];
  logic [WIDTH-1:0] c0;

  always_comb begin
    // A stage is free when it is empty or its contents move on. This ready
    // chain runs combinationally from out_ready back to in_ready.
    free = '0;
    free[DEPTH-1] = !valid_q[DEPTH-1] || out_ready;
    for (int unsigned k = DEPTH - 1; k > 0; k--) begin
      free[k-1] = !valid_q[k-1] || free[k];
    end

    vin      = '0;
    vin[0]   = in_valid;
    lin_x[0] = in_data;
    lin_s[0] = s_q;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      vin[k]   = valid_q[k-1];
      lin_x[k] = data_q[k-1];
      lin_s[k] = scap_q[k-1];
    end

`ifdef STAT_SEQ_KEY_EN
    c0 = s_q ^ key;
`else
    c0 = s_q;
`endif
    y[0] = gate_layer(lin_x[0], c0);
    for (int unsigned k = 1; k < DEPTH; k++) begin
      y[k] = gate_layer(lin_x[k], rotr(lin_s[k], k));
    end

    s_d = s_q;
    if (in_valid && free[0]) begin
      s_d = {s_q[WIDTH-2:0], s_q[WIDTH-1]} ^ in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      s_q     <= SEED_W;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
        scap_q[k] <= '0;
      end
    end else begin
      s_q <= s_d;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (free[k]) begin
          valid_q[k] <= vin[k];
          // Data changes only when a real word arrives, so an empty last
          // stage keeps presenting its previous result.
          if (vin[k]) begin
            data_q[k] <= y[k];
            scap_q[k] <= lin_s[k];
          end
        end
      end
    end
  end

  assign in_ready  = free[0];
  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: tb/tb_stat_seq_bench.sv
module tb_stat_seq_bench;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Small instance: WIDTH=8, DEPTH=2, SEED=1
  logic       iv8 = 1'b0, or8 = 1'b0;
  logic       ir8, ov8;
  logic [7:0] id8 = '0;
  logic [7:0] od8;
  // Large instance: WIDTH=32, DEPTH=4, SEED=1
  logic        iv32 = 1'b0, or32 = 1'b0;
  logic        ir32, ov32;
  logic [31:0] id32 = '0;
  logic [31:0] od32;
`ifdef STAT_SEQ_KEY_EN
  logic [7:0]  key8  = '0;
  logic [31:0] key32 = '0;
`endif

  stat_seq_bench #(.WIDTH(8), .DEPTH(2), .SEED(1)) u8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(ir8), .in_data(id8),
    .out_valid(ov8), .out_ready(or8), .out_data(od8)
`ifdef STAT_SEQ_KEY_EN
    , .key(key8)
`endif
  );

  stat_seq_bench #(.WIDTH(32), .DEPTH(4), .SEED(1)) u32 (
    .clk(clk), .rst(rst),
    .in_valid(iv32), .in_ready(ir32), .in_data(id32),
    .out_valid(ov32), .out_ready(or32), .out_data(od32)
`ifdef STAT_SEQ_KEY_EN
    , .key(key32)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model, bit by bit with explicit modular indices.
  function automatic logic [31:0] mlayer(input logic [31:0] x, input logic [31:0] s,
                                         input logic [31:0] k, input int w, input int j);
    logic [31:0] yv;
    logic a, b, c, o;
    yv = '0;
    for (int i = 0; i < w; i++) begin
      a = x[i];
      b = x[(i + 1) % w];
      c = s[(i + j) % w];
      if (j == 0) c = c ^ k[i];
      case (i % 4)
        0:       o = a & b;
        1:       o = a | b;
        2:       o = a ^ b;
        default: o = ~(a & b);
      endcase
      yv[i] = o ^ c;
    end
    return yv;
  endfunction

  function automatic logic [31:0] mres(input logic [31:0] x, input logic [31:0] s,
                                       input logic [31:0] k, input int w, input int d);
    logic [31:0] v;
    v = x;
    for (int j = 0; j < d; j++) v = mlayer(v, s, k, w, j);
    return v;
  endfunction

  function automatic logic [31:0] mnext(input logic [31:0] s, input logic [31:0] x, input int w);
    logic [31:0] mask;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    return (((s << 1) | (s >> (w - 1))) & mask) ^ x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    iv8 = 1'b0; iv32 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [4];
  logic [31:0] exp_q [$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] s_m, e;
    int words, cycles;
    logic tv;

    // Single-word results from reset (s=8'h01), computed by hand.
    vecs[0] = '{din: 8'h00, exp: 8'hCC};
    vecs[1] = '{din: 8'hFF, exp: 8'h3A};
    vecs[2] = '{din: 8'h01, exp: 8'hCC};
    vecs[3] = '{din: 8'hAA, exp: 8'hAB};

    // Reset state
    do_reset();
    or8 = 1'b1;
    #1;
    check("rst_out_valid", {31'd0, ov8}, 32'd0);
    check("rst_out_data", {24'd0, od8}, 32'd0);
    check("rst_in_ready", {31'd0, ir8}, 32'd1);
    check("rst_s", {24'd0, u8.s_q}, 32'h01);

    // Single word, latency DEPTH
    iv8 = 1'b1; id8 = 8'h00;
    tick();
    iv8 = 1'b0;
    check("lat_early_valid", {31'd0, ov8}, 32'd0);
    tick();
    check("lat_valid", {31'd0, ov8}, 32'd1);
    check("lat_data", {24'd0, od8}, 32'hCC);
    check("lat_s", {24'd0, u8.s_q}, 32'h02);
    tick();
    check("empty_valid", {31'd0, ov8}, 32'd0);
    check("empty_hold_data", {24'd0, od8}, 32'hCC);

    // Table of single words from reset
    for (int v = 0; v < 4; v++) begin
      do_reset();
      or8 = 1'b1; iv8 = 1'b1; id8 = vecs[v].din;
      tick();
      iv8 = 1'b0;
      tick();
      check($sformatf("tbl%0d_valid", v), {31'd0, ov8}, 32'd1);
      check($sformatf("tbl%0d_data", v), {24'd0, od8}, {24'd0, vecs[v].exp});
      check($sformatf("tbl%0d_model", v), mres({24'd0, vecs[v].din}, 32'h1, 32'h0, 8, 2),
            {24'd0, vecs[v].exp});
    end

    // Back-to-back: second word sees s_cap=8'h02, giving 8'hCF
    do_reset();
    or8 = 1'b1; iv8 = 1'b1; id8 = 8'h00;
    tick();
    tick();
    iv8 = 1'b0;
    check("b2b_v1", {31'd0, ov8}, 32'd1);
    check("b2b_d1", {24'd0, od8}, 32'hCC);
    tick();
    check("b2b_v2", {31'd0, ov8}, 32'd1);
    check("b2b_d2", {24'd0, od8}, 32'hCF);
    check("b2b_model", mres(32'h0, 32'h2, 32'h0, 8, 2), 32'hCF);
    check("b2b_s", {24'd0, u8.s_q}, 32'h04);

    // Stall: fill with out_ready low
    do_reset();
    or8 = 1'b0; iv8 = 1'b1; id8 = 8'h00;
    tick();
    id8 = 8'hFF;
    tick();
    id8 = 8'h55;
    #1;
    check("stall_in_ready", {31'd0, ir8}, 32'd0);
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("stall_hold_v%0d", c), {31'd0, ov8}, 32'd1);
      check($sformatf("stall_hold_d%0d", c), {24'd0, od8}, 32'hCC);
      check($sformatf("stall_hold_ir%0d", c), {31'd0, ir8}, 32'd0);
    end
    check("stall_s", {24'd0, u8.s_q}, mnext(mnext(32'h1, 32'h00, 8), 32'hFF, 8));
    iv8 = 1'b0; or8 = 1'b1;
    #1;
    check("drain_in_ready", {31'd0, ir8}, 32'd1);
    tick();
    check("drain_v2", {31'd0, ov8}, 32'd1);
    check("drain_d2", {24'd0, od8}, mres(32'hFF, 32'h02, 32'h0, 8, 2));
    tick();
    check("drain_empty", {31'd0, ov8}, 32'd0);

    // Asynchronous reset with two words in flight
    do_reset();
    or8 = 1'b1; iv8 = 1'b1; id8 = 8'h3C;
    tick();
    id8 = 8'h5A;
    tick();
    iv8 = 1'b0;
    check("arst_pre_valid", {31'd0, ov8}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", {31'd0, ov8}, 32'd0);
    check("arst_s", {24'd0, u8.s_q}, 32'h01);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("arst_no_pulse%0d", c), {31'd0, ov8}, 32'd0);
    end
    iv8 = 1'b1; id8 = 8'h00;
    tick();
    iv8 = 1'b0;
    tick();
    check("arst_after_v", {31'd0, ov8}, 32'd1);
    check("arst_after_d", {24'd0, od8}, 32'hCC);

`ifdef STAT_SEQ_KEY_EN
    // key=8'h01 cancels the seed bit in layer 0: 8'h88 then 8'h4C
    do_reset();
    key8 = 8'h01;
    or8 = 1'b1; iv8 = 1'b1; id8 = 8'h00;
    tick();
    iv8 = 1'b0;
    tick();
    check("key_valid", {31'd0, ov8}, 32'd1);
    check("key_data", {24'd0, od8}, 32'h4C);
    check("key_model", mres(32'h0, 32'h1, 32'h1, 8, 2), 32'h4C);
    key8 = 8'h00;
`endif

    // Random stream on the 32-bit, 4-deep instance
    do_reset();
    tick();
    s_m = 32'h1; words = 0; cycles = 0;
    while (words < 10000 && cycles < 60000) begin
      iv32 = ($urandom_range(3) != 0);
      id32 = $urandom;
      or32 = ($urandom_range(3) != 0);
      #1;
      if (iv32 && ir32) begin
        exp_q.push_back(mres(id32, s_m, 32'h0, 32, 4));
        s_m = mnext(s_m, id32, 32);
        words++;
      end
      if (ov32 && or32) begin
        if (exp_q.size() == 0) check("rnd_extra_word", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("rnd_data", od32, e);
        end
      end
      tick();
      cycles++;
    end
    check("rnd_words_sent", words, 32'd10000);
    iv32 = 1'b0; or32 = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (ov32) begin
        if (exp_q.size() == 0) check("rnd_extra_word", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check("rnd_data", od32, e);
        end
      end
      tick();
    end
    tv = ov32;
    check("rnd_drained", {31'd0, tv}, 32'd0);
    check("rnd_missing", exp_q.size(), 32'd0);
    check("rnd_state", u32.s_q, s_m);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
